// File: rtl/dram_cmd_sequencer.sv
// dram_cmd_sequencer: turns one request at a time into DDR4 PRE/ACT/RD/WR commands on half-rate DRAM edges.
// Open-page by default; defining DRAM_CLOSED_PAGE_EN precharges the bank after every access.
module dram_cmd_sequencer #(
  parameter int T_RCD   = 24,
  parameter int T_RP    = 24,
  parameter int T_RAS   = 52,
  parameter int T_CL    = 24,
  parameter int T_CWL   = 20,
  parameter int T_BURST = 4,
  parameter int T_RTP   = 12,
  parameter int T_WR    = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [1:0]  req_opcode,
  input  logic [32:0] req_address,
  output logic        req_ready,
  output logic        cmd_valid,
  output logic [1:0]  cmd_type,
  output logic [1:0]  cmd_bg,
  output logic [1:0]  cmd_bank,
  output logic [14:0] cmd_row,
  output logic [9:0]  cmd_col,
  output logic        resp_valid
);
`ifdef DRAM_CLOSED_PAGE_EN
  localparam bit CLOSED = 1'b1;
`else
  localparam bit CLOSED = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, PRE, ACT, COL, BURST, CLOSE} state_t;
  localparam logic [1:0] C_ACT = 2'd0, C_RD = 2'd1, C_WR = 2'd2, C_PRE = 2'd3;
  localparam logic [6:0] W_RP = 7'(T_RP), W_RCD = 7'(T_RCD), W_RD = 7'(T_CL + T_BURST);
  localparam logic [6:0] W_WRB = 7'(T_CWL + T_BURST), W_RAS = 7'(T_RAS), W_RTP = 7'(T_RTP);
  localparam logic [6:0] W_WRP = 7'(T_CWL + T_BURST + T_WR);
  state_t state, state_n;
  logic phase, wr_q, issue, resp, accept, hit, wait_done, pre_done, unused_bits;
  logic [1:0] ctype;
  logic [3:0] b_q, d_b;
  logic [14:0] row_q, d_row;
  logic [9:0] col_q;
  logic [6:0] wait_cnt, wait_val, pw_dec, pw_ld;
  logic [15:0] open_valid;
  logic [14:0] open_row [16];
  logic [6:0] prewait [16];
  assign unused_bits = ^req_address[3:0];
  assign d_b = {req_address[7:6], req_address[9:8]};
  assign d_row = req_address[32:18];
  assign req_ready = state == IDLE && !rst;
  assign accept = req_valid && req_ready;
  assign hit = open_valid[d_b] && open_row[d_b] == d_row;
  // A counter at 1 expires on this edge, so an edge acts when its decrement lands on 0.
  assign wait_done = phase && wait_cnt <= 7'd1;
  assign pre_done = phase && prewait[b_q] <= 7'd1;
  assign pw_dec = prewait[b_q] == 7'd0 ? 7'd0 : prewait[b_q] - 7'd1;
  assign wait_val = ctype == C_PRE ? W_RP : ctype == C_ACT ? W_RCD : ctype == C_RD ? W_RD : W_WRB;
  assign pw_ld = ctype == C_ACT ? W_RAS :
                 ctype == C_RD ? (pw_dec > W_RTP ? pw_dec : W_RTP) :
                 (pw_dec > W_WRP ? pw_dec : W_WRP);
  always_comb begin
    state_n = state;
    issue = 1'b0;
    resp = 1'b0;
    ctype = C_ACT;
    case (state)
      IDLE: if (accept) state_n = hit ? COL : open_valid[d_b] ? PRE : ACT;
      PRE: if (pre_done) begin
        issue = 1'b1;
        ctype = C_PRE;
        state_n = CLOSED ? CLOSE : ACT;
      end
      ACT: if (wait_done) begin
        issue = 1'b1;
        state_n = COL;
      end
      COL: if (wait_done) begin
        issue = 1'b1;
        ctype = wr_q ? C_WR : C_RD;
        state_n = BURST;
      end
      BURST: if (wait_done) begin
        resp = 1'b1;
        state_n = CLOSED ? PRE : IDLE;
      end
      CLOSE: if (wait_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      phase <= 1'b0;
      wait_cnt <= '0;
      open_valid <= '0;
      cmd_valid <= 1'b0;
      cmd_type <= '0;
      cmd_bg <= '0;
      cmd_bank <= '0;
      cmd_row <= '0;
      cmd_col <= '0;
      resp_valid <= 1'b0;
      wr_q <= 1'b0;
      b_q <= '0;
      row_q <= '0;
      col_q <= '0;
      for (int i = 0; i < 16; i++) prewait[i] <= '0;
    end else begin
      phase <= ~phase;
      state <= state_n;
      cmd_valid <= issue;
      resp_valid <= resp;
      wait_cnt <= issue ? wait_val : phase && wait_cnt != 7'd0 ? wait_cnt - 7'd1 : wait_cnt;
      for (int i = 0; i < 16; i++)
        prewait[i] <= issue && ctype != C_PRE && b_q == 4'(i) ? pw_ld :
                      phase && prewait[i] != 7'd0 ? prewait[i] - 7'd1 : prewait[i];
      if (accept) begin
        wr_q <= req_opcode == 2'd1;
        b_q <= d_b;
        row_q <= d_row;
        col_q <= {req_address[17:10], req_address[5:4]};
      end
      if (issue) begin
        cmd_type <= ctype;
        cmd_bg <= b_q[3:2];
        cmd_bank <= b_q[1:0];
        cmd_row <= ctype == C_ACT ? row_q : '0;
        cmd_col <= ctype == C_RD || ctype == C_WR ? col_q : '0;
        if (ctype == C_ACT) open_row[b_q] <= row_q;
        if (ctype == C_ACT || ctype == C_PRE) open_valid[b_q] <= ctype == C_ACT;
      end
    end
  end
endmodule

// File: tb/tb_dram_cmd_sequencer.sv
// tb_dram_cmd_sequencer: directed scenarios with hand-computed command/response clk numbers.
// clk N means the Nth posedge after reset release (first is 0); outputs are sampled on the following negedge.
module tb_dram_cmd_sequencer;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0;
  logic [1:0] req_opcode = '0;
  logic [32:0] req_address = '0;
  logic req_ready, cmd_valid, resp_valid;
  logic [1:0] cmd_type, cmd_bg, cmd_bank;
  logic [14:0] cmd_row;
  logic [9:0] cmd_col;
  int cyc = 0, checks = 0, errors = 0, at, acc, pre_at;
  logic [1:0] t, g, k;
  logic [14:0] r;
  logic [9:0] c;
  logic [32:0] addr_dec;

  dram_cmd_sequencer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_opcode(req_opcode),
    .req_address(req_address), .req_ready(req_ready), .cmd_valid(cmd_valid),
    .cmd_type(cmd_type), .cmd_bg(cmd_bg), .cmd_bank(cmd_bank), .cmd_row(cmd_row),
    .cmd_col(cmd_col), .resp_valid(resp_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst ? -1 : cyc + 1;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic [1:0] op, input logic [32:0] a);
    int n = 0;
    req_opcode = op;
    req_address = a;
    req_valid = 1'b1;
    #1;
    while (!req_ready && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    acc = n < 400 ? cyc + 1 : -1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_cmd();
    int n = 0;
    at = -1;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_valid && n < 400);
    if (cmd_valid) begin
      at = cyc;
      t = cmd_type;
      g = cmd_bg;
      k = cmd_bank;
      r = cmd_row;
      c = cmd_col;
    end
  endtask

  task automatic wait_resp();
    int n = 0;
    at = -1;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 400);
    if (resp_valid) at = cyc;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({req_ready, cmd_valid, resp_valid} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {req_ready, cmd_valid, resp_valid}); end
    checks++; if ({cmd_type, cmd_bg, cmd_bank, cmd_row, cmd_col} !== 31'd0) begin errors++; $display("FAIL reset_fields got %h want 0", {cmd_type, cmd_bg, cmd_bank, cmd_row, cmd_col}); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
  endtask

  task automatic test_cold_read();
    do_reset();
    send(2'd0, 33'h0);
    checks++; if (acc !== 0) begin errors++; $display("FAIL cold_accept got %0d want 0", acc); end
    wait_cmd();
    checks++; if (at !== 1 || {t, g, k, r, c} !== 31'd0) begin errors++; $display("FAIL cold_act got clk %0d type %0d bg %0d bank %0d row %h want clk 1 ACT all 0", at, t, g, k, r); end
    wait_cmd();
    checks++; if (at !== 49 || t !== 2'd1) begin errors++; $display("FAIL cold_rd got clk %0d type %0d want clk 49 type 1", at, t); end
    wait_resp();
    checks++; if (at !== 105) begin errors++; $display("FAIL cold_resp got clk %0d want 105", at); end
  endtask

  task automatic test_decode_write();
    do_reset();
    send(2'd1, addr_dec);
    wait_cmd();
    checks++; if (at !== 1 || {t, g, k, r, c} !== {2'd0, 2'd3, 2'd1, 15'h5A5A, 10'd0}) begin errors++; $display("FAIL dec_act got clk %0d type %0d bg %0d bank %0d row %h col %h want clk 1 0/3/1/5a5a/0", at, t, g, k, r, c); end
    wait_cmd();
    checks++; if (at !== 49 || {t, g, k, r, c} !== {2'd2, 2'd3, 2'd1, 15'h0, 10'h2C6}) begin errors++; $display("FAIL dec_wr got clk %0d type %0d bg %0d bank %0d row %h col %h want clk 49 2/3/1/0/2c6", at, t, g, k, r, c); end
    wait_resp();
    checks++; if (at !== 97) begin errors++; $display("FAIL dec_resp got clk %0d want 97", at); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(2'd0, addr_dec);
    wait_cmd();
    while (cyc < 20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({cmd_valid, req_ready, resp_valid} !== 3'b000) begin errors++; $display("FAIL midrst_flags got %b want 000", {cmd_valid, req_ready, resp_valid}); end
    checks++; if ({cmd_type, cmd_bg, cmd_bank, cmd_row, cmd_col} !== 31'd0) begin errors++; $display("FAIL midrst_fields got %h want 0", {cmd_type, cmd_bg, cmd_bank, cmd_row, cmd_col}); end
    rst = 1'b0;
    send(2'd0, addr_dec);
    checks++; if (acc !== 0) begin errors++; $display("FAIL midrst_accept got %0d want 0", acc); end
    wait_cmd();
    checks++; if (at !== 1 || t !== 2'd0 || r !== 15'h5A5A) begin errors++; $display("FAIL midrst_act got clk %0d type %0d row %h want clk 1 type 0 row 5a5a", at, t, r); end
  endtask

`ifdef DRAM_CLOSED_PAGE_EN
  task automatic test_closed_page();
    do_reset();
    send(2'd0, 33'h0);
    wait_cmd();
    wait_cmd();
    wait_resp();
    checks++; if (at !== 105) begin errors++; $display("FAIL cp_resp1 got clk %0d want 105", at); end
    wait_cmd();
    pre_at = at;
    checks++; if (at !== 107 || t !== 2'd3) begin errors++; $display("FAIL cp_pre1 got clk %0d type %0d want clk 107 type 3", at, t); end
    send(2'd0, 33'h0);
    checks++; if (acc !== 156) begin errors++; $display("FAIL cp_accept2 got %0d want 156", acc); end
    wait_cmd();
    checks++; if (at !== 157 || t !== 2'd0 || at - pre_at < 48) begin errors++; $display("FAIL cp_act2 got clk %0d type %0d want clk 157 type 0", at, t); end
    wait_cmd();
    checks++; if (at !== 205 || t !== 2'd1) begin errors++; $display("FAIL cp_rd2 got clk %0d type %0d want clk 205 type 1", at, t); end
    wait_resp();
    wait_cmd();
    checks++; if (at !== 263 || t !== 2'd3) begin errors++; $display("FAIL cp_pre2 got clk %0d type %0d want clk 263 type 3", at, t); end
  endtask
`else
  task automatic test_row_hit();
    do_reset();
    send(2'd0, 33'h0);
    wait_cmd();
    wait_cmd();
    wait_resp();
    send(2'd2, 33'h0_0000_0410);
    checks++; if (acc !== 106) begin errors++; $display("FAIL hit_accept got %0d want 106", acc); end
    wait_cmd();
    checks++; if (at !== 107 || {t, r, c} !== {2'd1, 15'd0, 10'd5}) begin errors++; $display("FAIL hit_rd got clk %0d type %0d row %h col %h want clk 107 type 1 row 0 col 5", at, t, r, c); end
    wait_resp();
    checks++; if (at !== 163) begin errors++; $display("FAIL hit_resp got clk %0d want 163", at); end
    @(negedge clk);
    checks++; if ({resp_valid, cmd_valid, cmd_type, cmd_col} !== {1'b0, 1'b0, 2'd1, 10'd5}) begin errors++; $display("FAIL hit_hold got resp %b valid %b type %0d col %h want 0 0 1 5", resp_valid, cmd_valid, cmd_type, cmd_col); end
  endtask

  task automatic test_row_conflict();
    do_reset();
    send(2'd0, 33'h0);
    wait_cmd();
    wait_cmd();
    wait_resp();
    send(2'd0, 33'h0_0004_0000);
    wait_cmd();
    checks++; if (at !== 107 || {t, r, c} !== {2'd3, 15'd0, 10'd0}) begin errors++; $display("FAIL conf_pre got clk %0d type %0d row %h col %h want clk 107 type 3 row 0 col 0", at, t, r, c); end
    wait_cmd();
    checks++; if (at !== 155 || {t, r} !== {2'd0, 15'd1}) begin errors++; $display("FAIL conf_act got clk %0d type %0d row %h want clk 155 type 0 row 1", at, t, r); end
    wait_cmd();
    checks++; if (at !== 203 || t !== 2'd1) begin errors++; $display("FAIL conf_rd got clk %0d type %0d want clk 203 type 1", at, t); end
    wait_resp();
    checks++; if (at !== 259) begin errors++; $display("FAIL conf_resp got clk %0d want 259", at); end
  endtask

  task automatic test_tras();
    do_reset();
    send(2'd1, 33'h0);
    wait_cmd();
    wait_cmd();
    wait_resp();
    checks++; if (at !== 97) begin errors++; $display("FAIL tras_wresp got clk %0d want 97", at); end
    send(2'd0, 33'h0_0004_0000);
    wait_cmd();
    checks++; if (at !== 137 || t !== 2'd3) begin errors++; $display("FAIL tras_pre got clk %0d type %0d want clk 137 type 3", at, t); end
    wait_cmd();
    checks++; if (at !== 185 || t !== 2'd0) begin errors++; $display("FAIL tras_act got clk %0d type %0d want clk 185 type 0", at, t); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send(2'd0, 33'h0);
    wait_cmd();
    wait_cmd();
    while (cyc < 59) @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy got %b want 0", req_ready); end
    send(2'd0, 33'h0_0000_0410);
    checks++; if (acc !== 106) begin errors++; $display("FAIL b2b_accept got %0d want 106", acc); end
    wait_cmd();
    checks++; if (at !== 107 || t !== 2'd1) begin errors++; $display("FAIL b2b_rd got clk %0d type %0d want clk 107 type 1", at, t); end
  endtask
`endif

  initial begin
    addr_dec = {15'h5A5A, 8'hB1, 2'b01, 2'b11, 2'b10, 4'hF};
    test_reset();
    test_cold_read();
    test_decode_write();
    test_reset_mid();
`ifdef DRAM_CLOSED_PAGE_EN
    test_closed_page();
`else
    test_row_hit();
    test_row_conflict();
    test_tras();
    test_back_to_back();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
